// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq
//   Sequencer for the shared multi-cycle multiplier / divider used by EX.
//   Detects a mul/div-class op in EX, fires exactly one start pulse to the
//   right unit, stalls EX until the result is captured, holds it until MEM
//   accepts it, and cancels cleanly on flush. A DIV_WAIT watchdog turns a
//   lost div_done into a div_err pulse and a zero result.
//
//   Optional feature (macro MULDIV_REM_REUSE_EN): keep the last divider
//   run {quot, rem, a, b, signed}; a later div-class op with matching
//   operands/signedness completes from that entry without starting the
//   divider.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   ex_valid, op, src1, src2    EX instruction and forwarded operands
//   ex_allowout, flush          MEM accept / pipeline kill
//   mul_start, mul_hi, mul_signed, mul_res, mul_done      multiplier side
//   div_start, div_signed, div_cancel, div_quot, div_rem, div_done  divider
//   md_a, md_b                  latched operands to both units
//   mul_out/_valid, div_out/_valid  captured result (one shared register)
//   ex_stall                    hold EX/IF/ID this cycle
//   div_err                     divider timeout pulse
module ex_muldiv_seq #(
  parameter int DIV_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [7:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        ex_allowout,
  input  logic        flush,
  output logic        mul_start,
  output logic        mul_hi,
  output logic        mul_signed,
  input  logic [31:0] mul_res,
  input  logic        mul_done,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_cancel,
  input  logic [31:0] div_quot,
  input  logic [31:0] div_rem,
  input  logic        div_done,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic [31:0] mul_out,
  output logic [31:0] div_out,
  output logic        mul_out_valid,
  output logic        div_out_valid,
  output logic        ex_stall,
  output logic        div_err
);

  // Opcode encodings shared with the decoder
  localparam logic [7:0] OP_MUL   = 8'h30;
  localparam logic [7:0] OP_MULH  = 8'h31;
  localparam logic [7:0] OP_MULHU = 8'h32;
  localparam logic [7:0] OP_DIV   = 8'h34;
  localparam logic [7:0] OP_MOD   = 8'h35;
  localparam logic [7:0] OP_DIVU  = 8'h36;
  localparam logic [7:0] OP_MODU  = 8'h37;

  localparam int CW = $clog2(DIV_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL_WAIT, S_DIV_WAIT, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [31:0]   md_a_q, md_a_d, md_b_q, md_b_d, res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_div_q, is_div_d, is_rem_q, is_rem_d;
  logic          mul_hi_q, mul_hi_d, mul_signed_q, mul_signed_d;
  logic          div_signed_q, div_signed_d;

  // Decode
  logic is_mul_op, is_div_op, md_op, dec_hi, dec_msgn, dec_dsgn, dec_rem;
  assign is_mul_op = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHU);
  assign is_div_op = (op == OP_DIV) || (op == OP_MOD) ||
                     (op == OP_DIVU) || (op == OP_MODU);
  assign md_op     = ex_valid & (is_mul_op | is_div_op);
  assign dec_hi    = (op == OP_MULH) || (op == OP_MULHU);
  assign dec_msgn  = (op == OP_MUL) || (op == OP_MULH);
  assign dec_dsgn  = (op == OP_DIV) || (op == OP_MOD);
  assign dec_rem   = (op == OP_MOD) || (op == OP_MODU);

  logic reuse_hit;
`ifdef MULDIV_REM_REUSE_EN
  logic        rv_q, rv_d, rs_q, rs_d;
  logic [31:0] rq_q, rq_d, rr_q, rr_d, ra_q, ra_d, rb_q, rb_d;
  assign reuse_hit = rv_q & is_div_op & (src1 == ra_q) & (src2 == rb_q) &
                     (dec_dsgn == rs_q);
`else
  assign reuse_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    md_a_d       = md_a_q;
    md_b_d       = md_b_q;
    res_d        = res_q;
    cnt_d        = '0;
    is_div_d     = is_div_q;
    is_rem_d     = is_rem_q;
    mul_hi_d     = mul_hi_q;
    mul_signed_d = mul_signed_q;
    div_signed_d = div_signed_q;
    mul_start    = 1'b0;
    div_start    = 1'b0;
    div_cancel   = 1'b0;
    div_err      = 1'b0;
`ifdef MULDIV_REM_REUSE_EN
    rv_d = rv_q; rs_d = rs_q; rq_d = rq_q; rr_d = rr_q; ra_d = ra_q; rb_d = rb_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (md_op && !flush) begin
          md_a_d       = src1;
          md_b_d       = src2;
          is_div_d     = is_div_op;
          is_rem_d     = dec_rem;
          mul_hi_d     = dec_hi;
          mul_signed_d = dec_msgn;
          div_signed_d = dec_dsgn;
          if (is_div_op) begin
            if (reuse_hit) begin
`ifdef MULDIV_REM_REUSE_EN
              res_d = dec_rem ? rr_q : rq_q;
`endif
              state_d = S_DONE;
            end else begin
              div_start = 1'b1;
              state_d   = S_DIV_WAIT;
            end
          end else begin
            mul_start = 1'b1;
            state_d   = S_MUL_WAIT;
          end
        end
      end
      S_MUL_WAIT: begin
        if (flush) state_d = S_IDLE;
        else if (mul_done) begin
          res_d   = mul_res;
          state_d = S_DONE;
        end
      end
      S_DIV_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (flush) begin
          div_cancel = 1'b1;
          state_d    = S_IDLE;
        end else if (div_done) begin
          res_d   = is_rem_q ? div_rem : div_quot;
          state_d = S_DONE;
`ifdef MULDIV_REM_REUSE_EN
          rv_d = 1'b1; rq_d = div_quot; rr_d = div_rem;
          ra_d = md_a_q; rb_d = md_b_q; rs_d = div_signed_q;
`endif
        // Counter is 0 in the first DIV_WAIT cycle, so the pulse lands
        // DIV_TIMEOUT cycles after the start pulse.
        end else if (cnt_q == CW'(DIV_TIMEOUT - 1)) begin
          div_err    = 1'b1;
          div_cancel = 1'b1;
          res_d      = '0;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (flush || ex_allowout) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef MULDIV_REM_REUSE_EN
    if (div_cancel) rv_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      md_a_q       <= '0;
      md_b_q       <= '0;
      res_q        <= '0;
      cnt_q        <= '0;
      is_div_q     <= 1'b0;
      is_rem_q     <= 1'b0;
      mul_hi_q     <= 1'b0;
      mul_signed_q <= 1'b0;
      div_signed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      md_a_q       <= md_a_d;
      md_b_q       <= md_b_d;
      res_q        <= res_d;
      cnt_q        <= cnt_d;
      is_div_q     <= is_div_d;
      is_rem_q     <= is_rem_d;
      mul_hi_q     <= mul_hi_d;
      mul_signed_q <= mul_signed_d;
      div_signed_q <= div_signed_d;
    end
  end

`ifdef MULDIV_REM_REUSE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv_q <= 1'b0; rs_q <= 1'b0;
      rq_q <= '0; rr_q <= '0; ra_q <= '0; rb_q <= '0;
    end else begin
      rv_q <= rv_d; rs_q <= rs_d;
      rq_q <= rq_d; rr_q <= rr_d; ra_q <= ra_d; rb_q <= rb_d;
    end
  end
`endif

  // Mode bits must be valid alongside the combinational start pulse, so in
  // IDLE they come straight from decode; afterwards from the latched copy.
  wire in_idle = (state_q == S_IDLE);
  assign mul_hi     = in_idle ? (md_op & is_mul_op & dec_hi)   : mul_hi_q;
  assign mul_signed = in_idle ? (md_op & is_mul_op & dec_msgn) : mul_signed_q;
  assign div_signed = in_idle ? (md_op & is_div_op & dec_dsgn) : div_signed_q;

  assign md_a          = md_a_q;
  assign md_b          = md_b_q;
  assign mul_out       = res_q;
  assign div_out       = res_q;
  assign mul_out_valid = (state_q == S_DONE) & ~is_div_q;
  assign div_out_valid = (state_q == S_DONE) &  is_div_q;
  assign ex_stall      = md_op & ~((state_q == S_DONE) & ex_allowout);

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Bench for ex_muldiv_seq. The bench plays multiplier and divider (results
// from plain arithmetic on the operands it drove) and predicts every output
// from an instruction-level timeline: start at k=0, done at k=lat, result
// visible from lat+1 until the release cycle. A negedge compare process
// checks the DUT against those predictions each cycle.
module tb_ex_muldiv_seq;
  localparam int TO = 40;
  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_MUL = 8'h30, OP_MULH = 8'h31, OP_MULHU = 8'h32;
  localparam logic [7:0] OP_DIV = 8'h34, OP_MOD = 8'h35, OP_DIVU = 8'h36, OP_MODU = 8'h37;

  logic clk = 1'b0, rst_n = 1'b0;
  logic ex_valid = 0, ex_allowout = 0, flush = 0, mul_done = 0, div_done = 0;
  logic [7:0]  op = '0;
  logic [31:0] src1 = '0, src2 = '0, mul_res = '0, div_quot = '0, div_rem = '0;
  logic mul_start, mul_hi, mul_signed, div_start, div_signed, div_cancel;
  logic mul_out_valid, div_out_valid, ex_stall, div_err;
  logic [31:0] md_a, md_b, mul_out, div_out;

  ex_muldiv_seq #(.DIV_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .op(op), .src1(src1), .src2(src2),
    .ex_allowout(ex_allowout), .flush(flush), .mul_start(mul_start), .mul_hi(mul_hi),
    .mul_signed(mul_signed), .mul_res(mul_res), .mul_done(mul_done),
    .div_start(div_start), .div_signed(div_signed), .div_cancel(div_cancel),
    .div_quot(div_quot), .div_rem(div_rem), .div_done(div_done), .md_a(md_a), .md_b(md_b),
    .mul_out(mul_out), .div_out(div_out), .mul_out_valid(mul_out_valid),
    .div_out_valid(div_out_valid), .ex_stall(ex_stall), .div_err(div_err));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Predicted outputs for the current cycle
  logic chk_en = 0;
  logic e_stall, e_ms, e_ds, e_cancel, e_err, e_mv, e_dv, e_held, e_md;
  logic e_hi, e_msg, e_dsg;
  logic [31:0] e_out, e_a, e_b;

  always @(negedge clk) if (chk_en) begin
    chk("ex_stall", 32'(ex_stall), 32'(e_stall));
    chk("mul_start", 32'(mul_start), 32'(e_ms));
    chk("div_start", 32'(div_start), 32'(e_ds));
    chk("div_cancel", 32'(div_cancel), 32'(e_cancel));
    chk("div_err", 32'(div_err), 32'(e_err));
    chk("mul_out_valid", 32'(mul_out_valid), 32'(e_mv));
    chk("div_out_valid", 32'(div_out_valid), 32'(e_dv));
    if (e_mv) chk("mul_out", mul_out, e_out);
    if (e_dv) chk("div_out", div_out, e_out);
    if (e_held) begin
      chk("mul_hi", 32'(mul_hi), 32'(e_hi));
      chk("mul_signed", 32'(mul_signed), 32'(e_msg));
      chk("div_signed", 32'(div_signed), 32'(e_dsg));
    end
    if (e_md) begin
      chk("md_a", md_a, e_a);
      chk("md_b", md_b, e_b);
    end
  end

  // Reuse-entry model: last completed divider run, dropped on any cancel.
  bit rv_m = 0, rs_m = 0;
  logic [31:0] ra_m = '0, rb_m = '0;

  task automatic clear_exp();
    e_stall = 0; e_ms = 0; e_ds = 0; e_cancel = 0; e_err = 0; e_mv = 0; e_dv = 0;
    e_held = 0; e_md = 0; e_hi = 0; e_msg = 0; e_dsg = 0; e_out = '0; e_a = '0; e_b = '0;
  endtask

  task automatic junk_units();
    mul_done = 0; div_done = 0;
    mul_res = 32'hDEAD_BEEF; div_quot = 32'hBAD0_0001; div_rem = 32'hBAD0_0002;
  endtask

  // lat: done offset from start (<0: never). hold: DONE cycles before
  // allowout. fl: flush cycle offset (<0: none). lit: hand-computed result.
  task automatic run_op(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int hold, input int fl, input logic [31:0] lit);
    bit isd, isr, sg, hi, msg, reuse, tmo;
    int dk, last;
    logic [31:0] q, r, res;
    logic [63:0] p;
    isd = (o == OP_DIV) || (o == OP_MOD) || (o == OP_DIVU) || (o == OP_MODU);
    isr = (o == OP_MOD) || (o == OP_MODU);
    sg  = (o == OP_DIV) || (o == OP_MOD);
    hi  = (o == OP_MULH) || (o == OP_MULHU);
    msg = (o == OP_MUL) || (o == OP_MULH);
`ifdef MULDIV_REM_REUSE_EN
    reuse = isd && rv_m && a == ra_m && b == rb_m && sg == rs_m;
`else
    reuse = 0;
`endif
    tmo  = isd && !reuse && (lat < 0 || lat >= TO);
    dk   = reuse ? 0 : (tmo ? TO : lat);
    last = dk + 1 + hold;
    if (sg) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
    else if (isd) begin q = a / b; r = a % b; end
    else begin q = '0; r = '0; end
    if (o == OP_MULHU) p = {32'b0, a} * {32'b0, b};
    else p = 64'($signed(a)) * 64'($signed(b));
    res = tmo ? 32'h0 : (isd ? (isr ? r : q) : (hi ? p[63:32] : p[31:0]));
    for (int k = 0; k <= last; k++) begin
      @(posedge clk); #1;
      if (k == dk + 1 && !(fl >= 1 && fl <= dk))
        chk(isd ? "div_out_lit" : "mul_out_lit", isd ? div_out : mul_out, lit);
      clear_exp(); junk_units();
      ex_valid = 1; op = o; src1 = a; src2 = b;
      flush = (k == fl);
      ex_allowout = (k == last) || (k == fl && k > dk);
      if (k == dk && !reuse && !tmo) begin
        if (isd) begin div_done = 1; div_quot = q; div_rem = r; end
        else begin mul_done = 1; mul_res = isd ? 32'h0 : res; end
      end
      e_ms = (k == 0) && !isd;
      e_ds = (k == 0) && isd && !reuse;
      e_stall = !(k > dk && ex_allowout);
      e_cancel = isd && !reuse && ((k == fl && k >= 1 && k <= dk) || (tmo && k == dk));
      e_err = tmo && k == dk && k != fl;
      e_mv = (k > dk) && !isd;
      e_dv = (k > dk) && isd;
      e_out = res;
      e_held = (k <= dk);
      e_hi = !isd && hi; e_msg = !isd && msg; e_dsg = isd && sg;
      e_md = (k >= 1); e_a = a; e_b = b;
      chk_en = 1;
      if (k == fl) break;
    end
    if (isd && !reuse) begin
      if (tmo || (fl >= 1 && fl <= dk)) rv_m = 0;
      else begin rv_m = 1; ra_m = a; rb_m = b; rs_m = sg; end
    end
  endtask

  // Quiet cycles; optional stale done pulses at cycle 'stale'; ev drives a
  // valid non-md instruction, which must never stall.
  task automatic idle(input int n, input int stale, input bit ev);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      clear_exp(); junk_units();
      ex_valid = ev; op = ev ? OP_ADD : 8'h00; src1 = 32'h1234; src2 = 32'h5678;
      flush = 0; ex_allowout = 1;
      mul_done = (k == stale); div_done = (k == stale);
      chk_en = 1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear_exp();
    #12;
    chk("rst_stall", 32'(ex_stall), 0);
    chk("rst_mul_start", 32'(mul_start), 0);
    chk("rst_div_start", 32'(div_start), 0);
    chk("rst_out", mul_out, 0);
    chk("rst_md_a", md_a, 0);
    chk("rst_md_b", md_b, 0);
    chk("rst_valid", 32'({mul_out_valid, div_out_valid}), 0);
    chk("rst_err_cancel", 32'({div_err, div_cancel}), 0);
    @(negedge clk); rst_n = 1;
    idle(2, -1, 0);
    run_op(OP_MUL,  32'd7, 32'd6, 2, 0, -1, 32'd42);
    run_op(OP_DIV,  32'hFFFF_FF9C, 32'd7, 33, 0, -1, 32'hFFFF_FFF2);  // -100/7
    run_op(OP_MOD,  32'hFFFF_FF9C, 32'd7, 33, 0, -1, 32'hFFFF_FFFE);  // -100%7
    run_op(OP_MULHU, 32'hFFFF_FFFF, 32'd2, 3, 5, -1, 32'd1);
    run_op(OP_MULH, 32'hFFFF_FFFD, 32'd5, 1, 0, -1, 32'hFFFF_FFFF);
    idle(1, -1, 1);
    run_op(OP_DIVU, 32'd1000, 32'd3, 30, 0, 10, 32'd0);   // flushed in wait
    idle(25, 20, 0);                                       // stale done ignored
    run_op(OP_MUL,  32'd7, 32'd6, 3, 0, -1, 32'd42);
    run_op(OP_MUL,  32'd3, 32'd3, 4, 0, 4, 32'd0);         // flush beats done
    idle(1, -1, 0);
    run_op(OP_DIV,  32'd9, 32'd4, -1, 0, -1, 32'd0);       // timeout
    run_op(OP_DIV,  32'd100, 32'd7, 33, 0, -1, 32'd14);
    run_op(OP_MOD,  32'd100, 32'd7, 33, 0, -1, 32'd2);
    run_op(OP_MODU, 32'h8000_0000, 32'd3, 5, 3, 7, 32'd2); // flush+allowout in DONE
    idle(3, -1, 1);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
